// File: rtl/nios_system_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_mem_pkg
//  Description : Shared constants and types for the on-chip RAM stream reader.
//                Holds the RAM geometry, the reader's state encoding and the
//                stream beat carried through the output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios_system_mem_pkg;

    localparam int ADDR_W    = 13;    // RAM word-address width
    localparam int DATA_W    = 32;    // RAM / stream data width
    localparam int MEM_DEPTH = 5120;  // RAM words, address wrap point

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/nios_system_mem_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_mem_stream_fifo
//  Description : Synchronous FIFO of stream beats. The head entry is read
//                straight out of the storage flops, so the output is fully
//                registered. The occupancy count feeds the reader's credit
//                check.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                push, push_beat   - write strobe and beat
//                pop               - consume head (ignored when empty)
//                head, valid       - head beat and non-empty flag
//                count             - current occupancy (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_system_mem_stream_fifo
    import nios_system_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  beat_t                    push_beat,
    input  logic                     pop,
    output beat_t                    head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    beat_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_pop;

    // Popping an empty FIFO is a no-op; the caller only pops on a handshake.
    assign w_do_pop = pop && (r_count != '0);

    // Storage has no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nios_system_mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_mem_stream_reader
//  Description : Avalon-MM read master for the single-port on-chip RAM that
//                turns a (start address, word count) command into an
//                Avalon-ST packet with backpressure. Reads are only issued
//                while the output FIFO has room for every word already in
//                flight, so the sink may stall at any time.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                cmd_valid/ready/addr/len   - command handshake
//                mem_*                      - RAM address/control/readdata
//                st_valid/ready/data/sop/eop- stream source
//                busy, done, err            - status
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_system_mem_stream_reader #(
    parameter int ADDR_W     = nios_system_mem_pkg::ADDR_W,
    parameter int DATA_W     = nios_system_mem_pkg::DATA_W,
    parameter int MEM_DEPTH  = nios_system_mem_pkg::MEM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                st_valid,
    input  logic                st_ready,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_sop,
    output logic                st_eop,
    output logic                busy,
    output logic                done,
    output logic                err
);

    import nios_system_mem_pkg::*;

    localparam int                CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]       c_fifo_depth = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   c_len_max    = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_addr_last  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   c_len_one    = (ADDR_W+1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_remaining;     // reads still to issue
    logic               r_first;         // next issue carries sop
    logic               r_inflight;      // a read was issued last cycle
    logic               r_inflight_sop;
    logic               r_inflight_eop;
    logic               r_err;

    logic               w_cmd_fire;
    logic               w_cmd_bad;
    logic               w_issue;
    logic               w_final_pop;
    logic               w_has_credit;
    logic               w_pop;
    logic [CW:0]        w_used;

    beat_t              w_push_beat;
    beat_t              w_head;
    logic               w_fifo_valid;
    logic [CW-1:0]      w_fifo_count;

    // ------------------------------------------------------------------
    // Credit: buffered words plus the read whose data arrives next cycle
    // must leave at least one free FIFO slot before another read goes out.
    // ------------------------------------------------------------------
    assign w_used       = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
    assign w_has_credit = (w_used < c_fifo_depth);

    assign w_pop        = st_valid && st_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_fire  = 1'b0;
        w_cmd_bad   = (cmd_len == '0) || (cmd_len > c_len_max);
        w_issue     = 1'b0;
        w_final_pop = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_fire = cmd_valid;
                if (cmd_valid && !w_cmd_bad) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = w_has_credit;
                if (w_has_credit && (r_remaining == c_len_one)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The eop beat is the last buffered word, so accepting it
                // implies the FIFO empties and nothing is in flight.
                w_final_pop = w_pop && w_head.eop;
                if (w_final_pop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address / length / in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_remaining    <= '0;
            r_first        <= 1'b0;
            r_inflight     <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_err      <= w_cmd_fire && w_cmd_bad;
            r_inflight <= w_issue;
            if (w_cmd_fire && !w_cmd_bad) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
                r_first     <= 1'b1;
            end else if (w_issue) begin
                r_addr         <= (r_addr == c_addr_last) ? '0 : r_addr + ADDR_W'(1);
                r_remaining    <= r_remaining - c_len_one;
                r_first        <= 1'b0;
                r_inflight_sop <= r_first;
                r_inflight_eop <= (r_remaining == c_len_one);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: RAM q is valid the cycle after the issue.
    // ------------------------------------------------------------------
    assign w_push_beat.data = mem_readdata;
    assign w_push_beat.sop  = r_inflight_sop;
    assign w_push_beat.eop  = r_inflight_eop;

    nios_system_mem_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_beat (w_push_beat),
        .pop       (w_pop),
        .head      (w_head),
        .valid     (w_fifo_valid),
        .count     (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Outputs. Handshake and status outputs are forced low while reset is
    // held, since the synchronous reset has not yet taken effect in the
    // first cycle it is asserted.
    // ------------------------------------------------------------------
    assign cmd_ready      = (r_state == IDLE) && !reset;
    assign busy           = (r_state != IDLE) && !reset;
    assign err            = r_err && !reset;
    assign done           = w_final_pop;

    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue && !reset;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign st_valid       = w_fifo_valid && !reset;
    assign st_data        = w_head.data;
    assign st_sop         = w_head.sop;
    assign st_eop         = w_head.eop;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_system_mem_stream_reader
//  Description : Self-checking bench for the RAM stream reader. A RAM with a
//                registered address sits behind the master; a scoreboard of
//                expected words (address mod depth, sop/eop flags) and an
//                expected read-address queue check every transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_mem_stream_reader;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MD = 5120;
    localparam int FD = 4;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata;
    logic          st_valid;
    logic          st_ready;
    logic [DW-1:0] st_data;
    logic          st_sop;
    logic          st_eop;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    int          addr_q[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          issued    = 0;
    int          accepted  = 0;
    int          cs_cnt    = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          t_cmd     = 0;
    int          first_cs_cyc    = -1;
    int          first_valid_cyc = -1;
    int          first_acc_cyc   = -1;
    int          last_acc_cyc    = -1;
    logic        mon_en    = 1'b0;
    logic        prev_stall;
    logic [33:0] prev_beat;
    exp_t        mon_e;
    int          mon_a;

    logic [31:0] ram [MD];
    logic [31:0] ram_q;

    nios_system_mem_stream_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_DEPTH  (MD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_data        (st_data),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // On-chip RAM: address registered, q straight from the array register.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken && !mem_write) begin
            ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard, sampled mid-cycle
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            check("mem_write_low", mem_write, 0);
            if (mem_chipselect) begin
                cs_cnt++;
                issued++;
                if (first_cs_cyc < 0) first_cs_cyc = cyc;
                if (addr_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("mem_address", mem_address, mon_a);
                end
                check("outstanding_le_depth", (issued - accepted) <= FD, 1);
            end
            if (prev_stall) begin
                check("stall_valid_held", st_valid, 1);
                check("stall_beat_stable", {st_data, st_sop, st_eop}, prev_beat);
            end
            if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            check("done_on_eop_accept", done, st_valid && st_ready && st_eop);
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("st_data", st_data, mon_e.d);
                    check("st_sop", st_sop, mon_e.s);
                    check("st_eop", st_eop, mon_e.e);
                end
                accepted++;
                last_acc_cyc = cyc;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            prev_stall = st_valid && !st_ready;
            prev_beat  = {st_data, st_sop, st_eop};
        end
    end

    // Present a command for one cycle; legal commands load the scoreboard.
    task automatic send_cmd(input int addr, input int len, input bit legal);
        @(posedge clk); #1;
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid       = 1'b1;
        cmd_addr        = AW'(addr);
        cmd_len         = (AW+1)'(len);
        t_cmd           = cyc;
        first_cs_cyc    = -1;
        first_valid_cyc = -1;
        first_acc_cyc   = -1;
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back('{d: 32'hA500_0000 + 32'((addr + i) % MD),
                                  s: (i == 0), e: (i == len - 1)});
                addr_q.push_back((addr + i) % MD);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Run until the done count reaches target; mode 1 randomises st_ready.
    task automatic wait_done(input int target, input bit rand_ready, input int max_cyc);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            @(posedge clk); #1;
            st_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        check("done_reached", done_cnt >= target, 1);
        check("done_once", done_cnt, target);
        check("all_words_delivered", exp_q.size(), 0);
        check("all_reads_issued", addr_q.size(), 0);
        check("busy_after_done", busy, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, c0, base, n, a, l;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        st_ready  = 1'b0;
        for (int k = 0; k < MD; k++) ram[k] = 32'hA500_0000 + 32'(k);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_chipselect", mem_chipselect, 0);
        reset = 1'b0;
        #1;
        check("cmd_ready_after_reset", cmd_ready, 1);
        check("byteenable_all_ones", mem_byteenable, 4'hF);
        check("clken_high", mem_clken, 1);
        mon_en   = 1'b1;
        st_ready = 1'b1;

        // Basic read with latency and throughput
        d0 = done_cnt;
        send_cmd(32'h010, 4, 1'b1);
        check("busy_after_accept", busy, 1);
        check("cmd_ready_while_busy", cmd_ready, 0);
        wait_done(d0 + 1, 1'b0, 50);
        check("first_read_latency", first_cs_cyc - t_cmd, 1);
        check("first_valid_latency", first_valid_cyc - t_cmd, 3);
        check("first_accept_latency", first_acc_cyc - t_cmd, 3);
        check("four_consecutive_words", last_acc_cyc - first_acc_cyc, 3);

        // Address wrap
        d0 = done_cnt;
        send_cmd(5118, 4, 1'b1);
        wait_done(d0 + 1, 1'b0, 50);

        // Random backpressure, random ranges
        for (int r = 0; r < 4; r++) begin
            a = $urandom_range(0, MD - 1);
            l = (r == 0) ? 16 : $urandom_range(1, 40);
            st_ready = 1'($urandom_range(0, 1));
            d0 = done_cnt;
            send_cmd(a, l, 1'b1);
            wait_done(d0 + 1, 1'b1, 2000);
        end

        // Illegal lengths
        st_ready = 1'b1;
        e0 = err_cnt;
        c0 = cs_cnt;
        send_cmd(0, 0, 1'b0);
        check("err_len0", err, 1);
        check("cmd_ready_len0", cmd_ready, 1);
        check("busy_len0", busy, 0);
        @(posedge clk); #1;
        check("err_len0_one_cycle", err, 0);
        send_cmd(32'h20, MD + 1, 1'b0);
        check("err_len_big", err, 1);
        check("cmd_ready_len_big", cmd_ready, 1);
        @(posedge clk); #1;
        check("err_len_big_one_cycle", err, 0);
        check("err_count", err_cnt - e0, 2);
        check("no_read_on_err", cs_cnt - c0, 0);

        // Largest legal length
        d0 = done_cnt;
        send_cmd(7, MD, 1'b1);
        wait_done(d0 + 1, 1'b0, MD + 100);

        // Reset mid-transfer
        base = accepted;
        send_cmd(0, 8, 1'b1);
        n = 0;
        while (accepted < base + 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("third_word_seen", accepted >= base + 3, 1);
        reset = 1'b1;
        #1;
        check("midrst_st_valid", st_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_chipselect", mem_chipselect, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        issued   = 0;
        accepted = 0;
        #1;
        check("postrst_cmd_ready", cmd_ready, 1);
        check("postrst_st_valid", st_valid, 0);
        check("postrst_busy", busy, 0);
        d0 = done_cnt;
        send_cmd(32'h100, 1, 1'b1);
        wait_done(d0 + 1, 1'b0, 50);
        check("len1_valid_latency", first_valid_cyc - t_cmd, 3);

        // Single word held off by the sink
        st_ready = 1'b0;
        c0 = cs_cnt;
        d0 = done_cnt;
        send_cmd(5119, 1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check("held_valid", st_valid, 1);
            check("held_data", st_data, 32'hA500_13FF);
            check("held_sop_eop", {st_sop, st_eop}, 2'b11);
            @(posedge clk); #1;
        end
        check("single_read_issued", cs_cnt - c0, 1);
        check("no_done_while_held", done_cnt - d0, 0);
        st_ready = 1'b1;
        wait_done(d0 + 1, 1'b0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_system_mem_stream_reader.md
Name: nios_system_mem_stream_reader

Overview:
- Avalon-MM read master that sits directly in front of the 5120x32 single-port on-chip RAM, driving its address, chipselect, write, byteenable and clken inputs.
- Accepts a command (start word address, word count), reads that range sequentially, and emits the words on a 32-bit Avalon-ST source with backpressure.
- The RAM has a 1-cycle read latency: address is registered, q is unregistered. A small credit-controlled FIFO absorbs in-flight data, so the sink can stall at any time without losing words.

Parameters:
- ADDR_W, 13, RAM word-address width
- DATA_W, 32, RAM/stream data width
- MEM_DEPTH, 5120, number of RAM words; address wrap point
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, legal 1..MEM_DEPTH
- mem_address  out  ADDR_W  to RAM address
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write; constant 0
- mem_byteenable  out  DATA_W/8  constant all-ones
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM readdata
- st_valid  out  1  stream word valid
- st_ready  in  1  sink ready
- st_data  out  DATA_W  stream word
- st_sop  out  1  first word of command
- st_eop  out  1  last word of command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, last word accepted by sink
- err  out  1  one-cycle pulse, illegal command rejected

Behaviour:
- Reset (synchronous): state IDLE; FIFO emptied; in-flight read discarded.
- While reset is high: cmd_ready, st_valid, busy, done, err, mem_chipselect are all 0.
- First cycle after reset deasserts: cmd_ready=1.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On handshake:
  - cmd_len==0 or cmd_len>MEM_DEPTH: err pulses next cycle, stay IDLE, no RAM access.
  - Otherwise: latch addr/len, go to ISSUE, busy=1.
- ISSUE:
  - A read is issued in a cycle where credit = FIFO_DEPTH - fifo_count - inflight > 0.
  - An issue cycle drives mem_chipselect=1 and mem_address=current address.
  - Data returned from a read issued at cycle t is written to the FIFO at the end of t+1 (inflight is 0 or 1).
  - Address increments per issue and wraps MEM_DEPTH-1 -> 0.
  - After the final issue, go to DRAIN.
- DRAIN: no further issues. When the FIFO is empty, inflight=0, and the final word has been accepted by the sink: go to IDLE, pulse done in that same cycle, busy drops next cycle.
- Latency: command accepted at cycle T -> first read at T+1 -> st_valid=1 at T+3 (FIFO output registered).
- Throughput: with st_ready held high, one word per cycle sustained.
- Stream rules:
  - st_data, st_sop and st_eop hold stable while st_valid=1 and st_ready=0.
  - st_sop=1 only on the first word of the command; st_eop=1 only on the last.
  - For len=1, sop and eop are both 1.
- FIFO never overflows: the credit check includes the in-flight read. Simultaneous push and pop on a full or empty FIFO is legal.
- cmd_valid is ignored while busy. cmd_ready=0 from the acceptance cycle until return to IDLE.
- mem_chipselect=0 in every non-issue cycle. mem_write is never 1.

Decomposition:
- Package nios_system_mem_pkg:
  - ADDR_W, DATA_W, MEM_DEPTH constants
  - state enum {IDLE, ISSUE, DRAIN}
  - stream beat struct {data, sop, eop}
- Sub-module nios_system_mem_stream_fifo: synchronous FIFO of stream beats, registered output, with count output used by the credit logic.

Test Plan:
- RAM preloaded with word k = 0xA5000000+k; cmd addr=0x010 len=4, st_ready=1 -> words 0xA5000010..0xA5000013 on four consecutive cycles from T+3; sop on the first, eop on the last; done pulses on the eop acceptance cycle.
- cmd addr=5118 len=4 -> mem_address sequence 5118, 5119, 0, 1; data 0xA50013FE, 0xA50013FF, 0xA5000000, 0xA5000001.
- len=16, st_ready toggled 1-0-0-1 randomly -> all 16 words in order, no duplicates or drops; data stable during stalls; mem_chipselect cycles never exceed FIFO_DEPTH words outstanding.
- cmd len=0, then len=5121 -> err pulses once per command; mem_chipselect stays 0; cmd_ready stays 1.
- cmd addr=0 len=8, reset asserted after the third accepted word -> next cycle st_valid=0, busy=0, mem_chipselect=0; new cmd addr=0x100 len=1 -> single word 0xA5000100 with sop=eop=1.
- len=1 at addr=5119 with st_ready=0 for 10 cycles -> exactly one read issued; st_valid held for all 10 cycles; word 0xA50013FF delivered on release; done pulses then.
